// File: rtl/dma_pcim_read_controller.sv
//------------------------------------------------------------------------------
// Module   : dma_pcim_read_controller
// Purpose  : Fetches a contiguous host-memory region over the PCIM AXI4 read
//            channels (AR/R) and streams it out as 512-bit packets through a
//            first-word-fall-through buffer with credit-based burst issue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dma_pcim_read_controller #(
  parameter int MAX_BURST_BEATS = 16,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic         clk,
  input  logic         rst,
  // request interface
  input  logic [63:0]  req_addr,
  input  logic [15:0]  req_beats,
  input  logic         req_valid,
  output logic         req_ready,
  // PCIM read address channel
  output logic [15:0]  cl_sh_pcim_arid,
  output logic [63:0]  cl_sh_pcim_araddr,
  output logic [7:0]   cl_sh_pcim_arlen,
  output logic [2:0]   cl_sh_pcim_arsize,
  output logic [18:0]  cl_sh_pcim_aruser,
  output logic         cl_sh_pcim_arvalid,
  input  logic         sh_cl_pcim_arready,
  // PCIM read data channel
  input  logic [15:0]  sh_cl_pcim_rid,
  input  logic [511:0] sh_cl_pcim_rdata,
  input  logic [1:0]   sh_cl_pcim_rresp,
  input  logic         sh_cl_pcim_rlast,
  input  logic         sh_cl_pcim_rvalid,
  output logic         cl_sh_pcim_rready,
  // packet stream
  output logic [511:0] packet_out,
  output logic         packet_out_valid,
  input  logic         packet_out_grant,
  // status
  output logic         done,
  output logic         rd_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [63:0]    addr;
  logic [15:0]    remaining;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  fifo_count;
  logic [6:0]     burst_nb;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [511:0]   mem [FIFO_DEPTH];

  logic           accept;
  logic           ar_hs;
  logic           push;
  logic           pop;
  logic           issue_ok;
  logic [6:0]     page_beats;
  logic [6:0]     rem_cap;
  logic [6:0]     max_cap;
  logic [6:0]     nb_a;
  logic [6:0]     nb;
  logic [31:0]    credits;
  logic           unused_sigs;

  // Constant AR fields and the always-ready R channel.
  assign cl_sh_pcim_arid   = 16'd0;
  assign cl_sh_pcim_arsize = 3'b110;
  assign cl_sh_pcim_aruser = 19'd0;
  assign cl_sh_pcim_rready = 1'b1;

  assign req_ready        = (state == IDLE);
  assign done             = (state == DONE);
  assign packet_out_valid = (fifo_count != '0);
  assign packet_out       = mem[rd_ptr];

  assign accept = req_valid & req_ready;
  assign ar_hs  = cl_sh_pcim_arvalid & sh_cl_pcim_arready;
  // Beats that arrive while idle (e.g. after a mid-transfer reset) are dropped.
  assign push   = sh_cl_pcim_rvalid & (state != IDLE);
  assign pop    = packet_out_valid & packet_out_grant;

  assign unused_sigs = ^{sh_cl_pcim_rid, sh_cl_pcim_rlast, req_addr[5:0]};

  // Burst sizing: limited by remaining beats, max burst and the 4 KB page end.
  always_comb begin
    page_beats = 7'd64 - {1'b0, addr[11:6]};
    rem_cap    = (remaining > 16'd64) ? 7'd64 : remaining[6:0];
    max_cap    = 7'(MAX_BURST_BEATS);
    nb_a       = (rem_cap < max_cap) ? rem_cap : max_cap;
    nb         = (nb_a < page_beats) ? nb_a : page_beats;
    credits    = 32'(FIFO_DEPTH) - 32'(fifo_count) - 32'(outstanding);
    issue_ok   = (state == ISSUE) && !cl_sh_pcim_arvalid &&
                 (remaining != 16'd0) && (credits >= 32'(nb));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (req_beats == 16'd0) ? DONE : ISSUE;
      ISSUE: if (ar_hs && (remaining == 16'(burst_nb))) state_nxt = DRAIN;
      DRAIN: if ((outstanding == '0) && (fifo_count == '0)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk, AR presentation, outstanding-beat and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr               <= 64'd0;
      remaining          <= 16'd0;
      outstanding        <= '0;
      burst_nb           <= 7'd0;
      cl_sh_pcim_arvalid <= 1'b0;
      cl_sh_pcim_araddr  <= 64'd0;
      cl_sh_pcim_arlen   <= 8'd0;
      rd_err             <= 1'b0;
    end else begin
      if (accept) begin
        addr      <= {req_addr[63:6], 6'd0};
        remaining <= req_beats;
      end else if (ar_hs) begin
        addr      <= addr + {51'd0, burst_nb, 6'd0};
        remaining <= remaining - 16'(burst_nb);
      end

      // AR is only raised from a clean slate, so it stays stable until taken.
      if (issue_ok) begin
        cl_sh_pcim_arvalid <= 1'b1;
        cl_sh_pcim_araddr  <= addr;
        cl_sh_pcim_arlen   <= 8'(nb - 7'd1);
        burst_nb           <= nb;
      end else if (ar_hs) begin
        cl_sh_pcim_arvalid <= 1'b0;
      end

      // Handshake and beat in the same cycle combine into one update.
      outstanding <= outstanding + (ar_hs ? CW'(burst_nb) : '0) - CW'(push);

      if (accept) rd_err <= 1'b0;
      else if (push && (sh_cl_pcim_rresp != 2'b00)) rd_err <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sh_cl_pcim_rdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_pcim_read_controller.sv
`timescale 1ns/1ps
`default_nettype none

module tb_dma_pcim_read_controller;

  localparam int MAXB  = 16;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  req_addr = '0;
  logic [15:0]  req_beats = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [15:0]  arid;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [18:0]  aruser;
  logic         arvalid;
  logic         arready = 1'b1;
  logic [511:0] rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [511:0] packet_out;
  logic         pv;
  logic         grant = 1'b0;
  logic         done;
  logic         rd_err;

  always #5 clk = ~clk;

  dma_pcim_read_controller #(.MAX_BURST_BEATS(MAXB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_beats(req_beats), .req_valid(req_valid), .req_ready(req_ready),
    .cl_sh_pcim_arid(arid), .cl_sh_pcim_araddr(araddr), .cl_sh_pcim_arlen(arlen),
    .cl_sh_pcim_arsize(arsize), .cl_sh_pcim_aruser(aruser), .cl_sh_pcim_arvalid(arvalid),
    .sh_cl_pcim_arready(arready),
    .sh_cl_pcim_rid(16'd0), .sh_cl_pcim_rdata(rdata), .sh_cl_pcim_rresp(rresp),
    .sh_cl_pcim_rlast(rlast), .sh_cl_pcim_rvalid(rvalid), .cl_sh_pcim_rready(rready),
    .packet_out(packet_out), .packet_out_valid(pv), .packet_out_grant(grant),
    .done(done), .rd_err(rd_err)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic [63:0] addr;
    logic [15:0] beats;
    int          n_ar;
    logic [63:0] ar0_addr;
    logic [7:0]  ar0_len;
    logic [63:0] arl_addr;
    logic [7:0]  arl_len;
  } vec_t;

  ar_t         ar_log[$];
  ar_t         ar_q[$];
  ar_t         cur;
  int          n_chk = 0;
  int          n_fail = 0;
  int          pops = 0;
  int          done_cnt = 0;
  int          arv_cycles = 0;
  logic [63:0] exp_addr = '0;
  logic [63:0] err_addr = '1;
  logic [63:0] rsp_addr = '0;
  int          rsp_left = 0;
  logic        sb_en = 1'b0;
  logic        lat_pending = 1'b0;
  logic [511:0] lat_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ar_beat_sum();
    int s = 0;
    foreach (ar_log[i]) s += int'(ar_log[i].len) + 1;
    return s;
  endfunction

  // AR slave: logs every handshake and checks burst legality.
  always @(negedge clk) begin
    if (arvalid) arv_cycles++;
    if (!rst && arvalid && arready) begin
      ar_t a;
      a.addr = araddr;
      a.len  = arlen;
      ar_log.push_back(a);
      ar_q.push_back(a);
      n_chk++;
      if ((int'(araddr[11:0]) + (int'(arlen) + 1) * 64 > 4096) || (int'(arlen) + 1 > MAXB) ||
          (araddr[5:0] != 6'd0) || (arsize != 3'b110) || (arid != 16'd0) || (aruser != 19'd0)) begin
        n_fail++;
        $display("FAIL ar_legal: got addr 0x%0h len %0d size %0d, required aligned, in-page, len<%0d, size 6",
                 araddr, arlen, arsize, MAXB);
      end
    end
  end

  // R slave: returns each logged burst one beat per cycle; data = replicated beat address.
  always @(posedge clk) begin
    #1;
    if (rsp_left == 0 && ar_q.size() != 0) begin
      cur = ar_q.pop_front();
      rsp_addr = cur.addr;
      rsp_left = int'(cur.len) + 1;
    end
    if (rsp_left != 0) begin
      rvalid = 1'b1;
      rdata  = {8{rsp_addr}};
      rresp  = (rsp_addr == err_addr) ? 2'b10 : 2'b00;
      rlast  = (rsp_left == 1);
      rsp_addr = rsp_addr + 64'd64;
      rsp_left--;
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
    end
  end

  // Consumer scoreboard, single-cycle latency check, R-channel health check.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rvalid) begin
      n_chk++;
      if (rready !== 1'b1 || dut.fifo_count == 7'(DEPTH)) begin
        n_fail++;
        $display("FAIL r_accept: got rready %0b count %0d, required rready 1 and count < %0d",
                 rready, dut.fifo_count, DEPTH);
      end
    end
    if (lat_pending) begin
      n_chk++;
      if (pv !== 1'b1 || packet_out !== lat_data) begin
        n_fail++;
        $display("FAIL latency: got valid %0b data[63:0] 0x%0h, required valid 1 data[63:0] 0x%0h",
                 pv, packet_out[63:0], lat_data[63:0]);
      end
    end
    lat_pending = sb_en && rvalid && !pv;
    lat_data    = rdata;
    if (pv && grant) begin
      n_chk++;
      if (packet_out !== {8{exp_addr}}) begin
        n_fail++;
        $display("FAIL packet_data: got [63:0] 0x%0h, required 0x%0h", packet_out[63:0], exp_addr);
      end
      exp_addr = exp_addr + 64'd64;
      pops++;
    end
  end

  task automatic start_req(input logic [63:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    req_addr  = a;
    req_beats = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string name);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < maxc) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (done_cnt == start) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required a done pulse", name, maxc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic setup(input logic [63:0] a, input logic g, input logic en);
    @(posedge clk); #1;
    ar_log.delete();
    pops     = 0;
    exp_addr = {a[63:6], 6'd0};
    grant    = g;
    sb_en    = en;
    arready  = 1'b1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   base;
    int   bad;
    logic seen;
    logic [63:0] cap_addr;
    logic [7:0]  cap_len;

    vecs[0] = '{64'h1000,        16'd40, 3, 64'h1000,        8'd15, 64'h1800,        8'd7};
    vecs[1] = '{64'h1FC0,        16'd4,  2, 64'h1FC0,        8'd0,  64'h2000,        8'd2};
    vecs[2] = '{64'h5F00,        16'd20, 2, 64'h5F00,        8'd3,  64'h6000,        8'd15};
    vecs[3] = '{64'h2345,        16'd1,  1, 64'h2340,        8'd0,  64'h2340,        8'd0};
    vecs[4] = '{64'h0,           16'd16, 1, 64'h0,           8'd15, 64'h0,           8'd15};
    vecs[5] = '{64'h1_0000_0FC0, 16'd2,  2, 64'h1_0000_0FC0, 8'd0,  64'h1_0000_1000, 8'd0};

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_arvalid",   64'(arvalid),   64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_rd_err",    64'(rd_err),    64'd0);
    chk("rst_pv",        64'(pv),        64'd0);
    chk("rst_rready",    64'(rready),    64'd1);
    chk("rst_araddr",    araddr,         64'd0);
    chk("rst_arlen",     64'(arlen),     64'd0);
    chk("rst_arsize",    64'(arsize),    64'd6);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven transfers with free-flowing arready and grant
    for (int i = 0; i < 6; i++) begin
      setup(vecs[i].addr, 1'b1, 1'b1);
      base = done_cnt;
      @(negedge clk);
      chk("idle_req_ready", 64'(req_ready), 64'd1);
      start_req(vecs[i].addr, vecs[i].beats);
      wait_done(800, "vec");
      chk("vec_n_ar", 64'(ar_log.size()), 64'(vecs[i].n_ar));
      if (ar_log.size() > 0) begin
        chk("vec_ar0_addr", ar_log[0].addr, vecs[i].ar0_addr);
        chk("vec_ar0_len",  64'(ar_log[0].len), 64'(vecs[i].ar0_len));
        chk("vec_arl_addr", ar_log[ar_log.size()-1].addr, vecs[i].arl_addr);
        chk("vec_arl_len",  64'(ar_log[ar_log.size()-1].len), 64'(vecs[i].arl_len));
      end
      chk("vec_pops",  64'(pops), 64'(vecs[i].beats));
      chk("vec_dones", 64'(done_cnt - base), 64'd1);
      chk("vec_rd_err", 64'(rd_err), 64'd0);
    end

    // Credit limit: grant held low, only FIFO_DEPTH beats may be requested
    setup(64'h10000, 1'b0, 1'b1);
    base = done_cnt;
    start_req(64'h10000, 16'd128);
    repeat (150) @(negedge clk);
    chk("credit_beats", 64'(ar_beat_sum()), 64'(DEPTH));
    chk("credit_arvalid", 64'(arvalid), 64'd0);
    chk("credit_pv", 64'(pv), 64'd1);
    repeat (50) @(negedge clk);
    chk("credit_beats_hold", 64'(ar_beat_sum()), 64'(DEPTH));
    chk("credit_pops_held", 64'(pops), 64'd0);
    @(posedge clk); #1;
    grant = 1'b1;
    wait_done(1500, "credit");
    chk("credit_pops", 64'(pops), 64'd128);
    chk("credit_total_beats", 64'(ar_beat_sum()), 64'd128);
    chk("credit_dones", 64'(done_cnt - base), 64'd1);

    // AR back-pressure and error response
    setup(64'h3000, 1'b1, 1'b1);
    arready  = 1'b0;
    err_addr = 64'h30C0;
    start_req(64'h3000, 16'd8);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = arvalid;
    end
    chk("stall_arvalid_seen", 64'(seen), 64'd1);
    cap_addr = araddr;
    cap_len  = arlen;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!arvalid || araddr != cap_addr || arlen != cap_len) bad++;
    end
    chk("stall_ar_stable", 64'(bad), 64'd0);
    chk("stall_araddr", cap_addr, 64'h3000);
    chk("stall_arlen", 64'(cap_len), 64'd7);
    @(posedge clk); #1;
    arready = 1'b1;
    wait_done(300, "stall");
    chk("err_rd_err_set", 64'(rd_err), 64'd1);
    chk("err_pops", 64'(pops), 64'd8);
    err_addr = '1;
    setup(64'h4000, 1'b1, 1'b1);
    start_req(64'h4000, 16'd1);
    @(negedge clk);
    chk("err_cleared_on_accept", 64'(rd_err), 64'd0);
    wait_done(100, "err_clear");

    // Zero-length request
    setup(64'h5000, 1'b1, 1'b1);
    base = done_cnt;
    arv_cycles = 0;
    start_req(64'h5000, 16'd0);
    @(negedge clk);
    chk("zero_done_now", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    chk("zero_dones", 64'(done_cnt - base), 64'd1);
    chk("zero_no_arvalid", 64'(arv_cycles), 64'd0);
    chk("zero_no_ar", 64'(ar_log.size()), 64'd0);

    // Reset mid-transfer, then late beats must be dropped
    setup(64'h8000, 1'b0, 1'b0);
    start_req(64'h8000, 16'd64);
    repeat (20) @(negedge clk);
    chk("mid_pv_before", 64'(pv), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_req_ready", 64'(req_ready), 64'd1);
    chk("mid_arvalid", 64'(arvalid), 64'd0);
    chk("mid_pv", 64'(pv), 64'd0);
    bad = 0;
    for (int k = 0; k < 200 && (rsp_left != 0 || ar_q.size() != 0 || rvalid); k++) begin
      @(negedge clk);
      if (pv) bad++;
    end
    chk("late_beats_dropped", 64'(bad), 64'd0);
    chk("late_r_idle", 64'(rvalid), 64'd0);

    // Recovery after reset
    setup(64'h9000, 1'b1, 1'b1);
    base = done_cnt;
    start_req(64'h9000, 16'd4);
    wait_done(100, "recover");
    chk("recover_pops", 64'(pops), 64'd4);
    chk("recover_dones", 64'(done_cnt - base), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
